// File: rtl/soc_system_config_pkg.sv
// Shared constants for the configuration bank: register offsets, field bit positions
// and the commit sequencer state encoding.
package soc_system_config_pkg;

  localparam int COUNT_W = 16;

  // Control/status/count registers sit directly above the NUM_CH shadow words
  localparam int OFS_CTRL   = 0;
  localparam int OFS_STATUS = 1;
  localparam int OFS_COUNT  = 2;

  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_ABORT  = 1;

  localparam int STAT_PENDING   = 0;
  localparam int STAT_WR_ERR    = 1;
  localparam int STAT_SYNC_MODE = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/soc_system_config_commit_fsm.sv
// Commit sequencer: holds an accepted commit until it may be applied, then pulses
// out_update and advances the commit counter.
//   state   | meaning
//   IDLE    | no commit outstanding, shadow edits accepted
//   PENDING | commit accepted, waiting for the boundary strobe (or none needed)
//   APPLY   | active <= shadow on the edge leaving this state
module soc_system_config_commit_fsm
  import soc_system_config_pkg::*;
#(
  parameter bit SYNC_MODE = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               commit_i,
  input  logic               abort_i,
  input  logic               sync_i,
  output logic               idle_o,
  output logic               apply_o,
  output logic               out_update_o,
  output logic [COUNT_W-1:0] count_o
);

  cfg_state_e         state_q;
  logic               sync_hit_q;
  logic               out_update_q;
  logic [COUNT_W-1:0] count_q;

  // The strobe is captured once in PENDING so the apply lands two edges after it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sync_hit_q   <= 1'b0;
      out_update_q <= 1'b0;
      count_q      <= '0;
    end else begin
      out_update_q <= 1'b0;
      sync_hit_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (commit_i && !abort_i) state_q <= ST_PENDING;
        end
        ST_PENDING: begin
          if (abort_i) begin
            state_q <= ST_IDLE;
          end else if (!SYNC_MODE || sync_hit_q) begin
            state_q <= ST_APPLY;
          end else begin
            sync_hit_q <= sync_i;
          end
        end
        ST_APPLY: begin
          state_q      <= ST_IDLE;
          out_update_q <= 1'b1;
          count_q      <= count_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign idle_o       = (state_q == ST_IDLE);
  assign apply_o      = (state_q == ST_APPLY);
  assign out_update_o = out_update_q;
  assign count_o      = count_q;

endmodule

// File: rtl/soc_system_config_bank.sv
// Avalon-MM configuration bank: NUM_CH shadow registers transferred atomically to the
// active outputs on commit, optionally aligned to a motion-segment boundary strobe.
module soc_system_config_bank
  import soc_system_config_pkg::*;
#(
  parameter int          NUM_CH    = 8,
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 4,
  parameter int          SYNC_MODE = 0,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  input  logic [3:0]               byteenable,
  output logic [31:0]              readdata,
  input  logic                     sync_in,
  output logic [NUM_CH*DATA_W-1:0] out_port,
  output logic                     out_update
);

  localparam int                 NB       = DATA_W / 8;
  localparam logic [DATA_W-1:0]  RST      = RESET_VAL[DATA_W-1:0];
  localparam logic [ADDR_W-1:0]  A_NCH    = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0]  A_CTRL   = ADDR_W'(NUM_CH + OFS_CTRL);
  localparam logic [ADDR_W-1:0]  A_STATUS = ADDR_W'(NUM_CH + OFS_STATUS);
  localparam logic [ADDR_W-1:0]  A_COUNT  = ADDR_W'(NUM_CH + OFS_COUNT);

  logic [DATA_W-1:0]  shadow_q [NUM_CH];
  logic [DATA_W-1:0]  active_q [NUM_CH];
  logic               wr_err_q, wr_err_d;
  logic               wr, shadow_wr, commit_wr, abort_wr, status_wr, reload;
  logic               idle, apply;
  logic [COUNT_W-1:0] count;

  assign wr        = chipselect & ~write_n;
  assign shadow_wr = wr && (address < A_NCH);
  assign commit_wr = wr && (address == A_CTRL) && writedata[CTRL_COMMIT];
  assign abort_wr  = wr && (address == A_CTRL) && writedata[CTRL_ABORT];
  assign status_wr = wr && (address == A_STATUS);
  // An abort during APPLY is too late: the transfer is already committed
  assign reload    = abort_wr && !apply;

  soc_system_config_commit_fsm #(
    .SYNC_MODE (SYNC_MODE != 0)
  ) u_fsm (
    .clk          (clk),
    .reset_n      (reset_n),
    .commit_i     (commit_wr),
    .abort_i      (abort_wr),
    .sync_i       (sync_in),
    .idle_o       (idle),
    .apply_o      (apply),
    .out_update_o (out_update),
    .count_o      (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= RST;
    end else if (reload) begin
      for (int i = 0; i < NUM_CH; i++) shadow_q[i] <= active_q[i];
    end else if (shadow_wr && idle) begin
      for (int i = 0; i < NUM_CH; i++)
        if (address == ADDR_W'(i))
          for (int k = 0; k < NB; k++)
            if (byteenable[k]) shadow_q[i][8*k +: 8] <= writedata[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) active_q[i] <= RST;
    end else if (apply) begin
      for (int i = 0; i < NUM_CH; i++) active_q[i] <= shadow_q[i];
    end
  end

  // A fresh error in the same cycle as its clear must survive
  assign wr_err_d = (shadow_wr && !idle) || (wr_err_q && !(status_wr && writedata[STAT_WR_ERR]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wr_err_q <= 1'b0;
    else          wr_err_q <= wr_err_d;
  end

  always_comb begin
    readdata = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (address == ADDR_W'(i)) readdata = 32'(shadow_q[i]);
    if (address == A_STATUS) begin
      readdata[STAT_PENDING]   = ~idle;
      readdata[STAT_WR_ERR]    = wr_err_q;
      readdata[STAT_SYNC_MODE] = (SYNC_MODE != 0);
    end
    if (address == A_COUNT) readdata[COUNT_W-1:0] = count;
  end

  always_comb begin
    out_port = '0;
    for (int i = 0; i < NUM_CH; i++) out_port[i*DATA_W +: DATA_W] = active_q[i];
  end

endmodule

// File: tb/tb_soc_system_config_bank.sv
// Bench for the configuration bank: an immediate-apply 8x32 instance and a boundary-synced
// 4x16 instance, both checked against a register-level model of the bank.
module tb_soc_system_config_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [3:0]  address;
  logic        cs0, cs1, write_n;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        sync0, sync1;
  logic [31:0] rd0, rd1;
  logic [255:0] out0;
  logic [63:0] out1;
  logic        upd0, upd1;

  int checks   = 0;
  int failures = 0;

  soc_system_config_bank #(
    .NUM_CH(8), .DATA_W(32), .ADDR_W(4), .SYNC_MODE(0), .RESET_VAL(32'h0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0),
    .write_n(write_n), .writedata(writedata), .byteenable(byteenable),
    .readdata(rd0), .sync_in(sync0), .out_port(out0), .out_update(upd0)
  );

  soc_system_config_bank #(
    .NUM_CH(4), .DATA_W(16), .ADDR_W(3), .SYNC_MODE(1), .RESET_VAL(32'h0000A5A5)
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address[2:0]), .chipselect(cs1),
    .write_n(write_n), .writedata(writedata), .byteenable(byteenable),
    .readdata(rd1), .sync_in(sync1), .out_port(out1), .out_update(upd1)
  );

  // Register-level model: shadow/active words, commit counter, error flag, pending flag
  logic [31:0] m_sh  [2][8];
  logic [31:0] m_act [2][8];
  logic [15:0] m_cnt [2];
  bit          m_err [2];
  bit          m_pend[2];

  function automatic int nch(int d);   return (d == 0) ? 8 : 4; endfunction
  function automatic int nlane(int d); return (d == 0) ? 4 : 2; endfunction
  function automatic int naddr(int d); return (d == 0) ? 16 : 8; endfunction
  function automatic logic [31:0] rv(int d); return (d == 0) ? 32'h0 : 32'h0000A5A5; endfunction

  function automatic logic [31:0] model_read(int d, int a);
    if (a < nch(d))       return m_sh[d][a];
    if (a == nch(d) + 1)  return {29'b0, (d == 1), m_err[d], m_pend[d]};
    if (a == nch(d) + 2)  return {16'b0, m_cnt[d]};
    return 32'h0;
  endfunction

  function automatic logic [31:0] get_out(int d, int i);
    if (d == 0) return out0[i*32 +: 32];
    return {16'h0, out1[i*16 +: 16]};
  endfunction

  function automatic logic get_upd(int d);
    return (d == 0) ? upd0 : upd1;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin m_sh[d][i] = rv(d); m_act[d][i] = rv(d); end
      m_cnt[d] = 16'h0; m_err[d] = 1'b0; m_pend[d] = 1'b0;
    end
  endtask

  task automatic m_apply(int d);
    for (int i = 0; i < 8; i++) m_act[d][i] = m_sh[d][i];
    m_cnt[d]  = m_cnt[d] + 16'h1;
    m_pend[d] = 1'b0;
  endtask

  task automatic m_reload(int d);
    for (int i = 0; i < 8; i++) m_sh[d][i] = m_act[d][i];
    m_pend[d] = 1'b0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(int d, int addr, logic [31:0] data, logic [3:0] be);
    @(negedge clk);
    address = 4'(addr); writedata = data; byteenable = be; write_n = 1'b0;
    if (d == 0) cs0 = 1'b1; else cs1 = 1'b1;
    @(posedge clk); #1;
    write_n = 1'b1; cs0 = 1'b0; cs1 = 1'b0;
  endtask

  task automatic rd(int d, int addr, output logic [31:0] data);
    @(negedge clk);
    address = 4'(addr);
    #1;
    data = (d == 0) ? rd0 : rd1;
  endtask

  task automatic sh_wr(int d, int ch, logic [31:0] data, logic [3:0] be);
    bus_wr(d, ch, data, be);
    if (m_pend[d]) m_err[d] = 1'b1;
    else
      for (int k = 0; k < nlane(d); k++)
        if (be[k]) m_sh[d][ch][8*k +: 8] = data[8*k +: 8];
  endtask

  task automatic chk_out(int d, string tag);
    for (int i = 0; i < nch(d); i++)
      chk($sformatf("%s_out%0d_ch%0d", tag, d, i), get_out(d, i), m_act[d][i]);
  endtask

  task automatic check_all(int d, string tag);
    logic [31:0] v;
    for (int a = 0; a < naddr(d); a++) begin
      rd(d, a, v);
      chk($sformatf("%s_rd%0d_a%0d", tag, d, a), v, model_read(d, a));
    end
    chk_out(d, tag);
  endtask

  // Commit with exact-latency checks; dut1 additionally needs a boundary strobe
  task automatic do_commit(int d);
    bus_wr(d, nch(d), 32'h1, 4'hF);
    m_pend[d] = 1'b1;
    chk_out(d, "c_e0");
    chk("c_upd_e0", 32'(get_upd(d)), 32'h0);
    if (d == 1) begin
      repeat ($urandom_range(0, 4)) begin
        @(posedge clk); #1;
        chk_out(d, "c_wait");
      end
      @(negedge clk); sync1 = 1'b1;
      @(posedge clk); #1; sync1 = 1'b0;
    end
    @(posedge clk); #1;
    chk_out(d, "c_e1");
    chk("c_upd_e1", 32'(get_upd(d)), 32'h0);
    @(posedge clk); #1;
    m_apply(d);
    chk_out(d, "c_e2");
    chk("c_upd_e2", 32'(get_upd(d)), 32'h1);
    @(posedge clk); #1;
    chk("c_upd_e3", 32'(get_upd(d)), 32'h0);
  endtask

  initial begin
    logic [31:0] v;
    reset_n = 1'b0; address = '0; cs0 = 1'b0; cs1 = 1'b0; write_n = 1'b1;
    writedata = '0; byteenable = '0; sync0 = 1'b0; sync1 = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;

    check_all(0, "rst");
    check_all(1, "rst");
    chk("rst_upd0", 32'(upd0), 32'h0);
    chk("rst_upd1", 32'(upd1), 32'h0);

    // Immediate apply, two-edge latency
    sh_wr(0, 2, 32'hDEADBEEF, 4'hF);
    do_commit(0);
    chk("t1_ch2", get_out(0, 2), 32'hDEADBEEF);
    rd(0, 10, v); chk("t1_count", v, 32'h1);

    // Single byte lane merge, invisible until committed
    sh_wr(0, 5, 32'h11223344, 4'hF);
    do_commit(0);
    sh_wr(0, 5, 32'h0000AB00, 4'b0010);
    rd(0, 5, v); chk("t2_merge", v, 32'h1122AB44);
    chk("t2_out_hold", get_out(0, 5), 32'h11223344);
    do_commit(0);
    chk("t2_out_new", get_out(0, 5), 32'h1122AB44);

    // Synced apply: strobe during the commit write is ignored, edits while pending are dropped
    sh_wr(1, 0, 32'h0000BEEF, 4'hF);
    sync1 = 1'b1;
    bus_wr(1, 4, 32'h1, 4'hF);
    sync1 = 1'b0;
    m_pend[1] = 1'b1;
    sh_wr(1, 0, 32'h00001111, 4'hF);
    rd(1, 5, v); chk("t3_status_pend", v, 32'h7);
    repeat (20) @(posedge clk);
    #1;
    rd(1, 5, v); chk("t3_status_hold", v, 32'h7);
    chk_out(1, "t3_hold");
    @(negedge clk); sync1 = 1'b1;
    @(posedge clk); #1;
    chk_out(1, "t3_s0");
    @(posedge clk); #1; sync1 = 1'b0;
    chk_out(1, "t3_s1");
    chk("t3_upd_s1", 32'(upd1), 32'h0);
    @(posedge clk); #1;
    m_apply(1);
    chk("t3_ch0", get_out(1, 0), 32'h0000BEEF);
    chk("t3_upd_s2", 32'(upd1), 32'h1);
    sync1 = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("t3_no_double", 32'(upd1), 32'h0);
    end
    sync1 = 1'b0;
    check_all(1, "t3_after");
    bus_wr(1, 5, 32'h2, 4'hF);
    m_err[1] = 1'b0;
    rd(1, 5, v); chk("t3_w1c", v, 32'h4);

    // Abort in IDLE discards edits; abort while pending cancels the commit
    sh_wr(1, 1, 32'h00000055, 4'hF);
    bus_wr(1, 4, 32'h2, 4'hF);
    m_reload(1);
    rd(1, 1, v); chk("t4_idle_abort", v, m_act[1][1]);
    sh_wr(1, 1, 32'h00001234, 4'hF);
    bus_wr(1, 4, 32'h1, 4'hF);
    m_pend[1] = 1'b1;
    repeat (3) @(posedge clk);
    bus_wr(1, 4, 32'h2, 4'hF);
    m_reload(1);
    @(negedge clk); sync1 = 1'b1;
    @(posedge clk); #1; sync1 = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("t4_no_upd", 32'(upd1), 32'h0);
    end
    check_all(1, "t4_abort");
    sh_wr(1, 2, 32'h00000077, 4'hF);
    bus_wr(1, 4, 32'h3, 4'hF);
    m_reload(1);
    check_all(1, "t4_both");

    // Randomised traffic against the model
    for (int n = 0; n < 160; n++) begin
      int d, r;
      d = n & 1;
      r = $urandom_range(0, 9);
      sync0 = 1'($urandom);
      if (r < 6) begin
        sh_wr(d, $urandom_range(0, nch(d) - 1), $urandom, 4'($urandom));
      end else if (r < 8) begin
        do_commit(d);
      end else if (r == 8) begin
        bus_wr(d, nch(d), 32'h2, 4'hF);
        m_reload(d);
      end else begin
        int a;
        a = $urandom_range(0, naddr(d) - 1);
        rd(d, a, v);
        chk($sformatf("rnd_rd%0d_a%0d", d, a), v, model_read(d, a));
      end
    end
    sync0 = 1'b0;
    check_all(0, "rnd");
    check_all(1, "rnd");

    // Counter wrap
    @(negedge clk);
    force dut0.u_fsm.count_q = 16'hFFFF;
    #1;
    release dut0.u_fsm.count_q;
    m_cnt[0] = 16'hFFFF;
    rd(0, 10, v); chk("t5_preload", v, 32'h0000FFFF);
    do_commit(0);
    rd(0, 10, v); chk("t5_wrap", v, 32'h0);

    // Reset while pending loses the commit
    sh_wr(1, 3, 32'h00009999, 4'hF);
    bus_wr(1, 4, 32'h1, 4'hF);
    m_pend[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b0;
    #2;
    m_reset();
    chk_out(1, "t5_async");
    chk("t5_async_upd", 32'(upd1), 32'h0);
    @(negedge clk); reset_n = 1'b1;
    check_all(0, "t5_rst");
    check_all(1, "t5_rst");
    @(negedge clk); sync1 = 1'b1;
    @(posedge clk); #1; sync1 = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("t5_no_apply", 32'(upd1), 32'h0);
    end
    check_all(1, "t5_post");

    // Unmapped addresses read zero and ignore writes
    bus_wr(0, 12, 32'hFFFFFFFF, 4'hF);
    bus_wr(1, 7, 32'hFFFFFFFF, 4'hF);
    for (int a = 11; a < 16; a++) begin
      rd(0, a, v); chk($sformatf("unmapped0_a%0d", a), v, 32'h0);
    end
    rd(1, 7, v); chk("unmapped1_a7", v, 32'h0);
    check_all(0, "final");
    check_all(1, "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
